// File: rtl/solver_pkg.sv
// Shared state encoding and fixed-point helpers for the escape-time solver.
package solver_pkg;

    typedef enum logic [1:0] {
        IDLE,
        MUL,
        UPD,
        DONE
    } state_e;

    // Widest coefficient the helpers below can carry; product math runs at twice this.
    localparam int MAX_W  = 64;
    localparam int PROD_W = 2 * MAX_W;
    localparam int THR_W  = MAX_W + 1;

    function automatic int calc_width(input int num_limbs, input int limb_bits);
        return num_limbs * limb_bits;
    endfunction

    function automatic logic signed [MAX_W:0] escape_threshold(input int radius, input int frac_bits);
        logic signed [MAX_W:0] t;
        t = THR_W'(radius);
        return t <<< frac_bits;
    endfunction

    // Full signed product floored by the binary-point shift; callers truncate to their width.
    function automatic logic signed [PROD_W-1:0] fx_mul(input logic signed [MAX_W-1:0] a,
                                                        input logic signed [MAX_W-1:0] b,
                                                        input int                      frac_bits);
        logic signed [PROD_W-1:0] p;
        p = PROD_W'(a) * PROD_W'(b);
        return p >>> frac_bits;
    endfunction

endpackage

// File: rtl/escape_solver_if.sv
// Host-side bundle of the solver: C limb writes, start/cap, and the result handshake.
interface escape_solver_if #(
    parameter int LIMB_SIZE_BITS  = 27,
    parameter int LIMB_INDEX_BITS = 1,
    parameter int ITER_BITS       = 16
);
    logic                       wr_real_en;
    logic                       wr_imag_en;
    logic [LIMB_INDEX_BITS-1:0] wr_limb;
    logic [LIMB_SIZE_BITS-1:0]  wr_data;
    logic [ITER_BITS-1:0]       max_iter;
    logic                       start;
    logic                       busy;
    logic                       out_valid;
    logic                       out_ready;
    logic [ITER_BITS-1:0]       iterations;
    logic                       escaped;

    modport master (
        output wr_real_en, wr_imag_en, wr_limb, wr_data, max_iter, start, out_ready,
        input  busy, out_valid, iterations, escaped
    );

    modport slave (
        input  wr_real_en, wr_imag_en, wr_limb, wr_data, max_iter, start, out_ready,
        output busy, out_valid, iterations, escaped
    );
endinterface

// File: rtl/solver_square_unit.sv
// Registered Zr^2, Zi^2 and Zr*Zi, each rescaled back to the solver's fixed-point format.
module solver_square_unit
    import solver_pkg::*;
#(
    parameter int WIDTH     = 54,
    parameter int FRAC_BITS = 46
) (
    input  logic                    clk_i,
    input  logic                    en_i,
    input  logic signed [WIDTH-1:0] zr_i,
    input  logic signed [WIDTH-1:0] zi_i,
    output logic signed [WIDTH-1:0] sq_r_o,
    output logic signed [WIDTH-1:0] sq_i_o,
    output logic signed [WIDTH-1:0] x_o
);
    logic signed [MAX_W-1:0] zr_ext;
    logic signed [MAX_W-1:0] zi_ext;
    logic signed [WIDTH-1:0] sq_r_q;
    logic signed [WIDTH-1:0] sq_i_q;
    logic signed [WIDTH-1:0] x_q;

    assign zr_ext = MAX_W'(zr_i);
    assign zi_ext = MAX_W'(zi_i);

    // Pure datapath: only read after a MUL cycle has loaded it, so no reset is needed.
    always_ff @(posedge clk_i) begin
        if (en_i) begin
            sq_r_q <= WIDTH'(fx_mul(zr_ext, zr_ext, FRAC_BITS));
            sq_i_q <= WIDTH'(fx_mul(zi_ext, zi_ext, FRAC_BITS));
            x_q    <= WIDTH'(fx_mul(zr_ext, zi_ext, FRAC_BITS));
        end
    end

    assign sq_r_o = sq_r_q;
    assign sq_i_o = sq_i_q;
    assign x_o    = x_q;
endmodule

// File: rtl/escape_solver.sv
// Single-point escape-time engine: limb-loaded C, iterate Z = Z^2 + C until escape or cap.
module escape_solver
    import solver_pkg::*;
#(
    parameter int LIMB_SIZE_BITS    = 27,
    parameter int NUM_LIMBS         = 2,
    parameter int LIMB_INDEX_BITS   = 1,
    parameter int FRAC_BITS         = 46,
    parameter int ITER_BITS         = 16,
    parameter int DIVERGENCE_RADIUS = 4
) (
    input logic            clk_i,
    input logic            rst_ni,
    escape_solver_if.slave bus
);
    localparam int WIDTH = calc_width(NUM_LIMBS, LIMB_SIZE_BITS);
    localparam int WP1   = WIDTH + 1;
    localparam logic signed [WIDTH:0] THRESH = WP1'(escape_threshold(DIVERGENCE_RADIUS, FRAC_BITS));

    state_e                     state_q, state_d;
    logic signed [WIDTH-1:0]    cr_q, cr_d, ci_q, ci_d;
    logic signed [WIDTH-1:0]    zr_q, zr_d, zi_q, zi_d;
    logic [ITER_BITS-1:0]       n_q, n_d, cap_q, cap_d, iter_q, iter_d;
    logic                       esc_q, esc_d;
    logic signed [WIDTH-1:0]    sq_r, sq_i, x;
    logic signed [WIDTH:0]      mag;
    logic [LIMB_INDEX_BITS-1:0] limb_idx;

    solver_square_unit #(
        .WIDTH     (WIDTH),
        .FRAC_BITS (FRAC_BITS)
    ) u_square (
        .clk_i  (clk_i),
        .en_i   (state_q == MUL),
        .zr_i   (zr_q),
        .zi_i   (zi_q),
        .sq_r_o (sq_r),
        .sq_i_o (sq_i),
        .x_o    (x)
    );

    assign limb_idx = bus.wr_limb;
    // One extra bit keeps the sum of two in-range squares from wrapping.
    assign mag      = WP1'(sq_r) + WP1'(sq_i);

    always_comb begin
        state_d = state_q;
        cr_d    = cr_q;
        ci_d    = ci_q;
        zr_d    = zr_q;
        zi_d    = zi_q;
        n_d     = n_q;
        cap_d   = cap_q;
        iter_d  = iter_q;
        esc_d   = esc_q;

        case (state_q)
            IDLE: begin
                for (int l = 0; l < NUM_LIMBS; l++) begin
                    if (int'(limb_idx) == l) begin
                        if (bus.wr_real_en) cr_d[l*LIMB_SIZE_BITS +: LIMB_SIZE_BITS] = bus.wr_data;
                        if (bus.wr_imag_en) ci_d[l*LIMB_SIZE_BITS +: LIMB_SIZE_BITS] = bus.wr_data;
                    end
                end
                if (bus.start) begin
                    state_d = MUL;
                    zr_d    = '0;
                    zi_d    = '0;
                    n_d     = '0;
                    cap_d   = bus.max_iter;
                end
            end
            MUL: state_d = UPD;
            UPD: begin
                if (mag > THRESH) begin
                    state_d = DONE;
                    esc_d   = 1'b1;
                    iter_d  = n_q;
                end else if (n_q == cap_q) begin
                    state_d = DONE;
                    esc_d   = 1'b0;
                    iter_d  = cap_q;
                end else begin
                    zr_d    = sq_r - sq_i + cr_q;
                    zi_d    = (x <<< 1) + ci_q;
                    n_d     = n_q + ITER_BITS'(1);
                    state_d = MUL;
                end
            end
            DONE: begin
                if (bus.out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            cr_q    <= '0;
            ci_q    <= '0;
            zr_q    <= '0;
            zi_q    <= '0;
            n_q     <= '0;
            cap_q   <= '0;
            iter_q  <= '0;
            esc_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cr_q    <= cr_d;
            ci_q    <= ci_d;
            zr_q    <= zr_d;
            zi_q    <= zi_d;
            n_q     <= n_d;
            cap_q   <= cap_d;
            iter_q  <= iter_d;
            esc_q   <= esc_d;
        end
    end

    assign bus.busy       = (state_q != IDLE);
    assign bus.out_valid  = (state_q == DONE);
    assign bus.iterations = iter_q;
    assign bus.escaped    = esc_q;
endmodule

// File: doc/escape_solver.md
# escape_solver

Parametrised single-point fractal escape-time engine. Generalises the limb-loaded solver to configurable precision (limb count × limb size) and adds a runtime iteration cap, an escaped/bounded flag and a valid/ready result handshake. It sits behind the host limb-write interface and feeds the pixel result collector; one instance solves one C point at a time.

## Interface
- LIMB_SIZE_BITS, 27, bits per coefficient limb
- NUM_LIMBS, 2, limbs per coefficient; WIDTH = NUM_LIMBS*LIMB_SIZE_BITS
- LIMB_INDEX_BITS, 1, width of limb index
- FRAC_BITS, 46, fractional bits of signed fixed-point values; WIDTH-FRAC_BITS ≥ 8 required
- ITER_BITS, 16, iteration counter width
- DIVERGENCE_RADIUS, 4, squared-magnitude escape threshold (integer)

- clock  in  1  sole clock, rising edge
- reset  in  1  asynchronous, active-low
- wr_real_en  in  1  write wr_data into Re(C) limb wr_limb
- wr_imag_en  in  1  write wr_data into Im(C) limb wr_limb
- wr_limb  in  LIMB_INDEX_BITS  limb index, 0 = least significant
- wr_data  in  LIMB_SIZE_BITS  limb data
- max_iter  in  ITER_BITS  iteration cap, sampled at start acceptance
- start  in  1  begin solving current C
- busy  out  1  high in any state except IDLE
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts result
- iterations  out  ITER_BITS  update count before escape or cap
- escaped  out  1  1 = diverged, 0 = hit max_iter

## Operation
- States: IDLE, MUL, UPD, DONE. Reset → IDLE, Z=0, n=0; outputs busy=0, out_valid=0, iterations=0, escaped=0; C registers cleared to 0.
- Limb writes honoured only in IDLE; ignored otherwise and when wr_limb ≥ NUM_LIMBS. Both enables in one cycle write the same limb of both coefficients.
- IDLE: start=1 → MUL; Z←0, n←0, cap←max_iter. start ignored in MUL/UPD/DONE.
- MUL: register sq_r=Zr², sq_i=Zi², x=Zr·Zi. Each product full 2·WIDTH signed, arithmetic right shift FRAC_BITS, truncated to WIDTH.
- UPD: mag = sq_r+sq_i at WIDTH+1 bits (no overflow).
  - mag > DIVERGENCE_RADIUS<<FRAC_BITS (strict) → DONE, escaped=1, iterations=n.
  - else n == cap → DONE, escaped=0, iterations=cap.
  - else Zr←sq_r−sq_i+Cr, Zi←2x+Ci (WIDTH wrap), n←n+1, → MUL.
- DONE: out_valid=1, outputs held stable until out_ready=1; that edge → IDLE, out_valid=0. iterations/escaped retain last value in IDLE.
- Valid C range: |Re|,|Im| ≤ 2; outside it results are defined by wrap arithmetic only.

## Timing
- Start accepted at edge T; result with iteration count k appears (out_valid=1) after edge T+2(k+1).
- max_iter=0 → out_valid after T+2, iterations=0, escaped=0.
- out_valid never drops without out_ready; out_ready while out_valid=0 has no effect.
- Next start accepted earliest the cycle after the handshake edge.
- Reset asserted mid-solve: immediate return to IDLE, out_valid=0, busy=0; C cleared.

## Structure
- Package solver_pkg: state enum, WIDTH derivation, escape-threshold constant function, fixed-point multiply-and-rescale function.
- Sub-module solver_square_unit: registered Zr², Zi², Zr·Zi with rescale; rest (control FSM, C limb registers, Z update, counter, handshake) in escape_solver.

## Test plan
- C=(0,0), max_iter=100 → iterations=100, escaped=0, out_valid after edge T+202.
- C=(1,0), max_iter=50 → iterations=3, escaped=1 (|Z|²=4 at Z=2 does not escape; Z=5 does).
- C=(2,0), max_iter=50 → iterations=2, escaped=1; C=(−2,0), max_iter=20 → iterations=20, escaped=0.
- Hold out_ready=0 ten cycles after result, pulse start and limb writes meanwhile → outputs stable, writes/start ignored, IDLE after out_ready; new C (0,1) then solved → iterations=max_iter, escaped=0.
- Write limb index ≥ NUM_LIMBS and write during busy → C unchanged (verify by repeating C=(1,0) result 3).
- Assert reset mid-MUL/UPD → busy=0, out_valid=0, iterations=0 asynchronously; after release, C=(2,0) solve gives iterations=2.
